// File: rtl/nwd_pkg.sv
// nwd_pkg: shared types for the GCD (NWD) feeder.
//   NWD_W       : GCD unit operand/result width.
//   nwd_state_t : feeder FSM states.
//   nwd_pair_t  : operand pair layout; FIFO words use this {a, b} packing.
package nwd_pkg;

  localparam int NWD_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_LOW,
    WAIT_HIGH,
    HOLD
  } nwd_state_t;

  typedef struct packed {
    logic [NWD_W-1:0] a;
    logic [NWD_W-1:0] b;
  } nwd_pair_t;

endpackage

// File: rtl/nwd_fifo.sv
// nwd_fifo: small operand-pair FIFO, {a, b} packed into 2*W bits.
// Ports:
//   clk, nrst       : clock, asynchronous active-low reset
//   push, push_data : write request (ignored while full) and data
//   pop             : read request (ignored while empty)
//   head_data       : entry at the head (valid when !empty)
//   full, empty     : occupancy flags
//   count           : number of stored entries
module nwd_fifo
  import nwd_pkg::*;
#(
  parameter int W     = NWD_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   push,
  input  logic [2*W-1:0]         push_data,
  input  logic                   pop,
  output logic [2*W-1:0]         head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [2*W-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Full blocks the push even when a pop happens in the same cycle.
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Storage holds data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nwd_feeder.sv
// nwd_feeder: buffers operand pairs and sequences them through the GCD unit.
// Pairs with a zero operand or equal operands are resolved here, because the
// GCD unit never finishes (or never writes its output) for them.
// Ports:
//   clk, nrst                     : clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b   : operand pair stream (in_ready = !full)
//   res_valid/res_ready/res_out   : result stream, one result per pair
//   res_bypass                    : result was produced without the GCD unit
//   core_start/core_ina/core_inb  : command to the GCD unit
//   core_ready/core_out           : GCD unit status and result
//   fifo_count                    : operand FIFO occupancy
module nwd_feeder
  import nwd_pkg::*;
#(
  parameter int W     = NWD_W,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_a,
  input  logic [W-1:0]           in_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [W-1:0]           res_out,
  output logic                   res_bypass,
  output logic                   core_start,
  output logic [W-1:0]           core_ina,
  output logic [W-1:0]           core_inb,
  input  logic                   core_ready,
  input  logic [W-1:0]           core_out,
  output logic [$clog2(DEPTH):0] fifo_count
);

  nwd_state_t     state;
  nwd_state_t     state_n;
  logic [W-1:0]   opa;
  logic [W-1:0]   opb;
  logic [W-1:0]   res_n;
  logic           byp_n;
  logic           op_load;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [2*W-1:0] head_data;
  logic [W-1:0]   head_a;
  logic [W-1:0]   head_b;

  nwd_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (in_valid),
    .push_data ({in_a, in_b}),
    .pop       (fifo_pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign {head_a, head_b} = head_data;
  assign in_ready  = !fifo_full;
  assign res_valid = (state == HOLD);
  // Operands stay registered, so the GCD unit sees them stable from
  // ISSUE until the result is captured.
  assign core_ina  = opa;
  assign core_inb  = opb;

  always_comb begin
    state_n    = state;
    res_n      = res_out;
    byp_n      = res_bypass;
    op_load    = 1'b0;
    fifo_pop   = 1'b0;
    core_start = 1'b0;
    case (state)
      // res_valid is always 0 here, so only FIFO emptiness gates the pop.
      // Degenerate pairs are decided on the head itself, giving the result
      // one cycle after the head appears.
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_load  = 1'b1;
          if (head_a == '0 || head_b == '0) begin
            res_n   = head_a | head_b;
            byp_n   = 1'b1;
            state_n = HOLD;
          end else if (head_a == head_b) begin
            res_n   = head_a;
            byp_n   = 1'b1;
            state_n = HOLD;
          end else begin
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (core_ready) begin
          core_start = 1'b1;
          state_n    = WAIT_LOW;
        end
      end
      // The unit drops ready at the edge that ends ISSUE; skip one cycle so
      // the pre-start ready level is not mistaken for completion.
      WAIT_LOW: state_n = WAIT_HIGH;
      WAIT_HIGH: begin
        if (core_ready) begin
          res_n   = core_out;
          byp_n   = 1'b0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      opa        <= '0;
      opb        <= '0;
      res_out    <= '0;
      res_bypass <= 1'b0;
    end else begin
      state      <= state_n;
      res_out    <= res_n;
      res_bypass <= byp_n;
      if (op_load) begin
        opa <= head_a;
        opb <= head_b;
      end
    end
  end

  // A GCD unit still ready one cycle after start broke the handshake; the
  // feeder carries on and takes whatever core_out shows when ready is seen.
  always @(posedge clk) begin
    if (nrst && state == WAIT_LOW) begin
      assert (!core_ready)
        else $warning("nwd_feeder: core_ready still high one cycle after core_start");
    end
  end

endmodule

// File: tb/tb_nwd_feeder.sv
module tb_nwd_feeder;

  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic                   clk;
  logic                   nrst;
  logic                   in_valid;
  logic                   in_ready;
  logic [W-1:0]           in_a;
  logic [W-1:0]           in_b;
  logic                   res_valid;
  logic                   res_ready;
  logic [W-1:0]           res_out;
  logic                   res_bypass;
  logic                   core_start;
  logic [W-1:0]           core_ina;
  logic [W-1:0]           core_inb;
  logic                   core_ready;
  logic [W-1:0]           core_out;
  logic [$clog2(DEPTH):0] fifo_count;

  int checks = 0;
  int errors = 0;

  // GCD unit: behavioural subtractive model, or a bench-driven stub.
  logic         stub_mode;
  logic         stub_ready;
  logic [W-1:0] stub_out;
  logic         m_ready;
  logic [W-1:0] m_out;
  logic [W-1:0] ma;
  logic [W-1:0] mb;

  assign core_ready = stub_mode ? stub_ready : m_ready;
  assign core_out   = stub_mode ? stub_out   : m_out;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_ready <= 1'b1;
      m_out   <= '0;
      ma      <= '0;
      mb      <= '0;
    end else if (!stub_mode && m_ready && core_start) begin
      ma      <= core_ina;
      mb      <= core_inb;
      m_ready <= 1'b0;
    end else if (!m_ready) begin
      if (ma == mb) begin
        m_out   <= ma;
        m_ready <= 1'b1;
      end else if (ma > mb) begin
        ma <= ma - mb;
      end else begin
        mb <= mb - ma;
      end
    end
  end

  nwd_feeder #(.W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_out    (res_out),
    .res_bypass (res_bypass),
    .core_start (core_start),
    .core_ina   (core_ina),
    .core_inb   (core_inb),
    .core_ready (core_ready),
    .core_out   (core_out),
    .fifo_count (fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observers sampled on the falling edge.
  logic [W-1:0] rq [$];
  logic         bq [$];
  int           start_cnt;
  int           valid_cycles;
  logic [W-1:0] last_ina;
  logic [W-1:0] last_inb;

  always @(negedge clk) begin
    if (core_start) begin
      start_cnt++;
      last_ina = core_ina;
      last_inb = core_inb;
    end
    if (res_valid) valid_cycles++;
    if (res_valid && res_ready) begin
      rq.push_back(res_out);
      bq.push_back(res_bypass);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    rq.delete();
    bq.delete();
    start_cnt    = 0;
    valid_cycles = 0;
  endtask

  task automatic wait_results(input int n, input int budget, input string name);
    int k = 0;
    while (rq.size() < n && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (rq.size() < n) begin
      errors++;
      $display("FAIL %s_timeout got %0d results want %0d", name, rq.size(), n);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    stub_mode = 1'b0; stub_ready = 1'b1; stub_out = '0;
    clear_mon();
    tick(); tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_fifo_count got %0d want 0", fifo_count); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    checks++; if (res_out !== 8'd0) begin errors++; $display("FAIL reset_res_out got %0d want 0", res_out); end
    checks++; if (res_bypass !== 1'b0) begin errors++; $display("FAIL reset_res_bypass got %b want 0", res_bypass); end
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start got %b want 0", core_start); end
    checks++; if (core_ina !== 8'd0 || core_inb !== 8'd0) begin errors++; $display("FAIL reset_core_in got %0d,%0d want 0,0", core_ina, core_inb); end
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_gcd_basic();
    stub_mode = 1'b0; res_ready = 1'b1;
    clear_mon();
    in_a = 8'd12; in_b = 8'd18; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_results(1, 60, "gcd_basic");
    tick(); tick();
    checks++; if (start_cnt != 1) begin errors++; $display("FAIL gcd_basic_starts got %0d want 1", start_cnt); end
    checks++; if (last_ina !== 8'd12 || last_inb !== 8'd18) begin errors++; $display("FAIL gcd_basic_core_in got %0d,%0d want 12,18", last_ina, last_inb); end
    checks++; if (rq.size() != 1 || rq[0] !== 8'd6) begin errors++; $display("FAIL gcd_basic_res got %0d (n=%0d) want 6", (rq.size() > 0) ? rq[0] : 8'hxx, rq.size()); end
    checks++; if (bq.size() != 1 || bq[0] !== 1'b0) begin errors++; $display("FAIL gcd_basic_bypass got %b want 0", (bq.size() > 0) ? bq[0] : 1'bx); end
    checks++; if (valid_cycles != 1) begin errors++; $display("FAIL gcd_basic_valid_cycles got %0d want 1", valid_cycles); end
  endtask

  task automatic test_bypass();
    logic [W-1:0] exp_r [3];
    logic [W-1:0] got;
    exp_r[0] = 8'd7; exp_r[1] = 8'd9; exp_r[2] = 8'd0;
    stub_mode = 1'b0; res_ready = 1'b1;
    clear_mon();
    in_a = 8'd7; in_b = 8'd7; in_valid = 1'b1;
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bypass_early_valid got %b want 0", res_valid); end
    in_a = 8'd0; in_b = 8'd9;
    tick();
    checks++; if (res_valid !== 1'b1 || res_out !== 8'd7 || res_bypass !== 1'b1) begin
      errors++; $display("FAIL bypass_latency got v=%b r=%0d b=%b want v=1 r=7 b=1", res_valid, res_out, res_bypass);
    end
    in_a = 8'd0; in_b = 8'd0;
    tick();
    in_valid = 1'b0;
    wait_results(3, 40, "bypass");
    checks++; if (start_cnt != 0) begin errors++; $display("FAIL bypass_starts got %0d want 0", start_cnt); end
    for (int i = 0; i < 3; i++) begin
      got = (i < rq.size()) ? rq[i] : 8'hxx;
      checks++; if (got !== exp_r[i]) begin errors++; $display("FAIL bypass_res%0d got %0d want %0d", i, got, exp_r[i]); end
      checks++; if (i >= bq.size() || bq[i] !== 1'b1) begin errors++; $display("FAIL bypass_flag%0d got %b want 1", i, (i < bq.size()) ? bq[i] : 1'bx); end
    end
  endtask

  task automatic test_full();
    logic [W-1:0] pa [5];
    logic [W-1:0] pb [5];
    logic [W-1:0] exp_r [5];
    logic [W-1:0] got;
    pa[0] = 8'd12; pb[0] = 8'd18; exp_r[0] = 8'd6;
    pa[1] = 8'd8;  pb[1] = 8'd12; exp_r[1] = 8'd4;
    pa[2] = 8'd9;  pb[2] = 8'd6;  exp_r[2] = 8'd3;
    pa[3] = 8'd15; pb[3] = 8'd10; exp_r[3] = 8'd5;
    pa[4] = 8'd21; pb[4] = 8'd14; exp_r[4] = 8'd7;
    stub_mode = 1'b0; res_ready = 1'b0;
    clear_mon();
    for (int i = 0; i < 5; i++) begin
      in_a = pa[i]; in_b = pb[i]; in_valid = 1'b1;
      tick();
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", fifo_count); end
    // Keep offering a pair while full; it must not be taken.
    in_a = 8'd99; in_b = 8'd33;
    tick(); tick(); tick();
    in_valid = 1'b0;
    checks++; if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL full_hold got count=%0d rdy=%b want 4,0", fifo_count, in_ready); end
    checks++; if (res_valid !== 1'b1 || res_out !== 8'd6) begin errors++; $display("FAIL full_held_res got v=%b r=%0d want 1,6", res_valid, res_out); end
    res_ready = 1'b1;
    wait_results(5, 400, "full");
    tick(); tick();
    checks++; if (rq.size() != 5) begin errors++; $display("FAIL full_res_count got %0d want 5", rq.size()); end
    checks++; if (start_cnt != 5) begin errors++; $display("FAIL full_starts got %0d want 5", start_cnt); end
    for (int i = 0; i < 5; i++) begin
      got = (i < rq.size()) ? rq[i] : 8'hxx;
      checks++; if (got !== exp_r[i]) begin errors++; $display("FAIL full_res%0d got %0d want %0d", i, got, exp_r[i]); end
      checks++; if (i >= bq.size() || bq[i] !== 1'b0) begin errors++; $display("FAIL full_flag%0d got %b want 0", i, (i < bq.size()) ? bq[i] : 1'bx); end
    end
  endtask

  task automatic test_issue_stall();
    stub_mode = 1'b1; stub_ready = 1'b0; stub_out = 8'd0; res_ready = 1'b1;
    clear_mon();
    in_a = 8'd12; in_b = 8'd18; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (core_start !== 1'b0 || start_cnt != 0) begin errors++; $display("FAIL stall_start got %b cnt=%0d want 0,0", core_start, start_cnt); end
    checks++; if (core_ina !== 8'd12 || core_inb !== 8'd18) begin errors++; $display("FAIL stall_core_in got %0d,%0d want 12,18", core_ina, core_inb); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL stall_res_valid got %b want 0", res_valid); end
    stub_ready = 1'b1;
    #1;
    checks++; if (core_start !== 1'b1) begin errors++; $display("FAIL stall_release_start got %b want 1", core_start); end
    tick();
    stub_ready = 1'b0;
    tick(); tick();
    stub_out = 8'd6; stub_ready = 1'b1;
    wait_results(1, 10, "stall");
    checks++; if (start_cnt != 1) begin errors++; $display("FAIL stall_starts got %0d want 1", start_cnt); end
    checks++; if (rq.size() != 1 || rq[0] !== 8'd6 || bq[0] !== 1'b0) begin errors++; $display("FAIL stall_res got %0d want 6 (n=%0d)", (rq.size() > 0) ? rq[0] : 8'hxx, rq.size()); end
  endtask

  task automatic test_wait_low_err();
    stub_mode = 1'b1; stub_ready = 1'b1; stub_out = 8'd42; res_ready = 1'b1;
    clear_mon();
    in_a = 8'd12; in_b = 8'd18; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_results(1, 20, "wait_low");
    tick();
    checks++; if (start_cnt != 1) begin errors++; $display("FAIL wait_low_starts got %0d want 1", start_cnt); end
    checks++; if (rq.size() != 1 || rq[0] !== 8'd42 || bq[0] !== 1'b0) begin errors++; $display("FAIL wait_low_res got %0d want 42 (n=%0d)", (rq.size() > 0) ? rq[0] : 8'hxx, rq.size()); end
    stub_mode = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    stub_mode = 1'b0; res_ready = 1'b1;
    clear_mon();
    in_valid = 1'b1;
    in_a = 8'd12; in_b = 8'd18; tick();
    in_a = 8'd8;  in_b = 8'd12; tick();
    in_a = 8'd9;  in_b = 8'd6;  tick();
    in_valid = 1'b0;
    tick();
    checks++; if (fifo_count !== 3'd2 || res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_pre got count=%0d v=%b want 2,0", fifo_count, res_valid); end
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    #1;
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", fifo_count); end
    checks++; if (res_valid !== 1'b0 || core_start !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_ctrl got v=%b s=%b rdy=%b want 0,0,1", res_valid, core_start, in_ready);
    end
    clear_mon();
    tick();
    in_a = 8'd4; in_b = 8'd6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_results(1, 60, "rstmid");
    tick(); tick();
    checks++; if (rq.size() != 1 || rq[0] !== 8'd2 || bq[0] !== 1'b0) begin errors++; $display("FAIL rstmid_res got %0d want 2 (n=%0d)", (rq.size() > 0) ? rq[0] : 8'hxx, rq.size()); end
  endtask

  initial begin
    test_reset();
    test_gcd_basic();
    test_bypass();
    test_full();
    test_issue_stall();
    test_wait_low_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
